// File: rtl/inst_enc_pkg.sv
// Shared types and RV32 encoding constants for the instruction stream encoder.
package inst_enc_pkg;

  // Descriptor opcode; codes 9..15 are illegal.
  typedef enum logic [3:0] {
    OpAdd  = 4'd0,
    OpSub  = 4'd1,
    OpMul  = 4'd2,
    OpAnd  = 4'd3,
    OpOr   = 4'd4,
    OpAddi = 4'd5,
    OpLw   = 4'd6,
    OpSw   = 4'd7,
    OpBeq  = 4'd8
  } op_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_ADDI = 3'b000;
  localparam logic [2:0] F3_LW   = 3'b010;
  localparam logic [2:0] F3_SW   = 3'b010;
  localparam logic [2:0] F3_BEQ  = 3'b000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;
  localparam logic [6:0] F7_MUL  = 7'b0000001;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StDrain,
    StDone
  } state_e;

endpackage

// File: rtl/inst_word_encoder.sv
// Combinational descriptor-to-RV32 encoder; illegal descriptors become a NOP.
module inst_word_encoder
  import inst_enc_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [12:0] imm,
  output logic [31:0] word,
  output logic        illegal
);

  // I/S immediates are 12 bits; the 13-bit input must sign-extend from bit 11.
  logic imm12_fits;
  assign imm12_fits = (imm[12] == imm[11]);

  always_comb begin
    word    = NOP_WORD;
    illegal = 1'b0;
    case (op_e'(op))
      OpAdd: word = {F7_BASE, rs2, rs1, F3_ADD, rd, OP_R};
      OpSub: word = {F7_SUB, rs2, rs1, F3_ADD, rd, OP_R};
      OpMul: word = {F7_MUL, rs2, rs1, F3_ADD, rd, OP_R};
      OpAnd: word = {F7_BASE, rs2, rs1, F3_AND, rd, OP_R};
      OpOr:  word = {F7_BASE, rs2, rs1, F3_OR, rd, OP_R};
      OpAddi: begin
        if (imm12_fits) word = {imm[11:0], rs1, F3_ADDI, rd, OP_IMM};
        else            illegal = 1'b1;
      end
      OpLw: begin
        if (imm12_fits) word = {imm[11:0], rs1, F3_LW, rd, OP_LOAD};
        else            illegal = 1'b1;
      end
      OpSw: begin
        if (imm12_fits) word = {imm[11:5], rs2, rs1, F3_SW, imm[4:0], OP_STORE};
        else            illegal = 1'b1;
      end
      OpBeq: begin
        if (!imm[0]) word = {imm[12], imm[10:5], rs2, rs1, F3_BEQ, imm[4:1], imm[11], OP_BRANCH};
        else         illegal = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/inst_stream_encoder.sv
// Session-based loader: accepts instruction descriptors, encodes them and writes
// them sequentially into instruction memory through a one-entry output register.
module inst_stream_encoder
  import inst_enc_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [3:0]       in_op_i,
  input  logic [4:0]       in_rd_i,
  input  logic [4:0]       in_rs1_i,
  input  logic [4:0]       in_rs2_i,
  input  logic [12:0]      in_imm_i,
  input  logic             in_last_i,
  output logic             mem_valid_o,
  input  logic             mem_ready_i,
  output logic [31:0]      mem_addr_o,
  output logic [31:0]      mem_data_o,
  output logic [CNT_W-1:0] count_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);

  localparam logic [CNT_W-1:0] DepthCnt = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] LastCnt  = CNT_W'(DEPTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             err_q, err_d;
  logic             mem_valid_q, mem_valid_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic [31:0]      mem_data_q, mem_data_d;

  logic [31:0] enc_word;
  logic        enc_illegal;
  logic        slot_free;
  logic        accept;
  logic        last_slot;
  logic        session_end;
  logic        start_ok;

  inst_word_encoder u_word_encoder (
    .op      (in_op_i),
    .rd      (in_rd_i),
    .rs1     (in_rs1_i),
    .rs2     (in_rs2_i),
    .imm     (in_imm_i),
    .word    (enc_word),
    .illegal (enc_illegal)
  );

  // The output register can take a new word if empty or being written out now.
  assign slot_free   = !mem_valid_q || mem_ready_i;
  assign in_ready_o  = (state_q == StLoad) && (count_q < DepthCnt) && slot_free;
  assign accept      = in_valid_i && in_ready_o;
  assign last_slot   = (count_q == LastCnt);
  assign session_end = accept && (in_last_i || last_slot);
  assign start_ok    = (state_q == StIdle) && start_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_i) state_d = StLoad;
      StLoad:  if (session_end) state_d = StDrain;
      StDrain: if (!mem_valid_q) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy_o = (state_q == StLoad) || (state_q == StDrain);
    done_o = (state_q == StDone);
  end

  always_comb begin
    count_d = count_q;
    err_d   = err_q;
    if (start_ok) begin
      count_d = '0;
      err_d   = 1'b0;
    end
    if (accept) begin
      count_d = count_q + CNT_W'(1);
      // Filling the last slot without in_last_i is an overflow.
      if (enc_illegal || (last_slot && !in_last_i)) err_d = 1'b1;
    end
  end

  always_comb begin
    mem_valid_d = mem_valid_q;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    if (mem_valid_q && mem_ready_i) mem_valid_d = 1'b0;
    if (accept) begin
      mem_valid_d = 1'b1;
      mem_addr_d  = BASE_ADDR + (32'(count_q) << 2);
      mem_data_d  = enc_word;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      count_q     <= '0;
      err_q       <= 1'b0;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
    end else begin
      count_q     <= count_d;
      err_q       <= err_d;
      mem_valid_q <= mem_valid_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
    end
  end

  assign mem_valid_o = mem_valid_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_data_o  = mem_data_q;
  assign count_o     = count_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_inst_stream_encoder.sv
// Randomized bench for inst_stream_encoder with a queue-based session model.
module tb_inst_stream_encoder;

  localparam logic [31:0] BASE  = 32'h0000_0100;
  localparam int          DEPTH = 256;
  localparam logic [31:0] BASE2 = 32'h0000_0040;

  typedef struct {
    logic [3:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [12:0] imm;
    logic        last;
    logic [31:0] word;
    logic        ill;
  } desc_t;

  logic        clk;
  logic        rst_i;
  logic        start_i, in_valid_i, in_last_i, mem_ready_i;
  logic [3:0]  in_op_i;
  logic [4:0]  in_rd_i, in_rs1_i, in_rs2_i;
  logic [12:0] in_imm_i;
  logic        in_ready_o, mem_valid_o, busy_o, done_o, err_o;
  logic [31:0] mem_addr_o, mem_data_o;
  logic [8:0]  count_o;

  logic        start2, valid2, mready2;
  logic        in_ready2, mem_valid2, busy2, done2, err2;
  logic [31:0] mem_addr2, mem_data2;
  logic [1:0]  count2;

  int n_chk = 0;
  int n_bad = 0;

  // Model state
  logic [63:0] q[$];
  desc_t       sess[$];
  desc_t       cur;
  bit          m_loading, m_draining, acc;
  int          m_count, m_drain_idle, n_done;
  logic        m_err;

  inst_stream_encoder #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .in_valid_i(in_valid_i),
    .in_ready_o(in_ready_o), .in_op_i(in_op_i), .in_rd_i(in_rd_i), .in_rs1_i(in_rs1_i),
    .in_rs2_i(in_rs2_i), .in_imm_i(in_imm_i), .in_last_i(in_last_i),
    .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .count_o(count_o), .busy_o(busy_o), .done_o(done_o),
    .err_o(err_o)
  );

  inst_stream_encoder #(.BASE_ADDR(BASE2), .DEPTH(2)) dut2 (
    .clk_i(clk), .rst_i(rst_i), .start_i(start2), .in_valid_i(valid2),
    .in_ready_o(in_ready2), .in_op_i(in_op_i), .in_rd_i(in_rd_i), .in_rs1_i(in_rs1_i),
    .in_rs2_i(in_rs2_i), .in_imm_i(in_imm_i), .in_last_i(in_last_i),
    .mem_valid_o(mem_valid2), .mem_ready_i(mready2), .mem_addr_o(mem_addr2),
    .mem_data_o(mem_data2), .count_o(count2), .busy_o(busy2), .done_o(done2),
    .err_o(err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Returns {illegal, word} from the RV32 field layouts.
  function automatic logic [32:0] ref_encode(input desc_t d);
    logic [31:0] w;
    logic        ill;
    logic [12:0] i;
    i   = d.imm;
    ill = 1'b0;
    w   = 32'h0000_0013;
    case (d.op)
      4'd0: w = {7'h00, d.rs2, d.rs1, 3'b000, d.rd, 7'h33};
      4'd1: w = {7'h20, d.rs2, d.rs1, 3'b000, d.rd, 7'h33};
      4'd2: w = {7'h01, d.rs2, d.rs1, 3'b000, d.rd, 7'h33};
      4'd3: w = {7'h00, d.rs2, d.rs1, 3'b111, d.rd, 7'h33};
      4'd4: w = {7'h00, d.rs2, d.rs1, 3'b110, d.rd, 7'h33};
      4'd5, 4'd6, 4'd7: begin
        if ($signed(i) < -2048 || $signed(i) > 2047) ill = 1'b1;
        else if (d.op == 4'd5) w = {i[11:0], d.rs1, 3'b000, d.rd, 7'h13};
        else if (d.op == 4'd6) w = {i[11:0], d.rs1, 3'b010, d.rd, 7'h03};
        else w = {i[11:5], d.rs2, d.rs1, 3'b010, i[4:0], 7'h23};
      end
      4'd8: begin
        if (i[0]) ill = 1'b1;
        else w = {i[12], i[10:5], d.rs2, d.rs1, 3'b000, i[4:1], i[11], 7'h63};
      end
      default: ill = 1'b1;
    endcase
    return {ill, w};
  endfunction

  function automatic desc_t mk(input int op, input int rd, input int rs1, input int rs2,
                               input int imm, input bit last);
    desc_t       d;
    logic [32:0] r;
    d.op = 4'(op); d.rd = 5'(rd); d.rs1 = 5'(rs1); d.rs2 = 5'(rs2);
    d.imm = 13'(imm); d.last = last;
    r = ref_encode(d);
    d.word = r[31:0];
    d.ill  = r[32];
    return d;
  endfunction

  function automatic desc_t mkw(input int op, input int rd, input int rs1, input int rs2,
                                input int imm, input bit last, input logic [31:0] word);
    desc_t d;
    d = mk(op, rd, rs1, rs2, imm, last);
    d.word = word;
    return d;
  endfunction

  task automatic drive_cur();
    in_op_i = cur.op; in_rd_i = cur.rd; in_rs1_i = cur.rs1; in_rs2_i = cur.rs2;
    in_imm_i = cur.imm; in_last_i = cur.last;
  endtask

  task automatic model_reset();
    q.delete();
    m_loading = 0; m_draining = 0; m_count = 0; m_err = 1'b0; m_drain_idle = 0;
  endtask

  // Called at a falling edge with inputs set: check, advance model, go to next falling edge.
  task automatic tick();
    bit          exp_ready, exp_done, idle;
    logic [31:0] a;
    #2;
    exp_ready = m_loading && (m_count < DEPTH) && (q.size() == 0 || mem_ready_i);
    exp_done  = m_draining && (m_drain_idle >= 1);
    chk("in_ready", 32'(in_ready_o), 32'(exp_ready));
    chk("mem_valid", 32'(mem_valid_o), 32'(q.size() != 0));
    if (q.size() != 0) begin
      chk("mem_addr", mem_addr_o, q[0][63:32]);
      chk("mem_data", mem_data_o, q[0][31:0]);
    end
    chk("count", 32'(count_o), 32'(m_count));
    chk("err", 32'(err_o), 32'(m_err));
    chk("busy", 32'(busy_o), 32'(m_loading || (m_draining && !exp_done)));
    chk("done", 32'(done_o), 32'(exp_done));
    idle = !m_loading && !m_draining;
    if (exp_done) begin
      m_draining = 0;
      n_done++;
    end else if (m_draining && q.size() == 0) begin
      m_drain_idle++;
    end
    if (q.size() != 0 && mem_ready_i) void'(q.pop_front());
    acc = in_valid_i && exp_ready;
    if (acc) begin
      a = BASE + 32'(m_count * 4);
      q.push_back({a, cur.word});
      m_count++;
      if (cur.ill) m_err = 1'b1;
      if (cur.last || m_count == DEPTH) begin
        if (!cur.last) m_err = 1'b1;
        m_loading = 0; m_draining = 1; m_drain_idle = 0;
      end
    end
    if (idle && start_i) begin
      m_loading = 1; m_count = 0; m_err = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic run_session(input int valid_pct, input int ready_pct, input int stall);
    int idx = 0;
    int cyc = 0;
    int done0;
    int stall_left;
    done0 = n_done;
    stall_left = stall;
    in_valid_i = 0; start_i = 1; tick(); start_i = 0;
    while (n_done == done0 && cyc < 500) begin
      if (idx < sess.size()) begin
        cur = sess[idx];
        drive_cur();
        in_valid_i = ($urandom_range(0, 99) < valid_pct);
      end else begin
        in_valid_i = 0;
      end
      if (stall_left > 0 && idx >= 1) begin
        mem_ready_i = 0;
        stall_left--;
      end else begin
        mem_ready_i = ($urandom_range(0, 99) < ready_pct);
      end
      tick();
      if (acc) idx++;
      cyc++;
    end
    chk("session_done", 32'(n_done - done0), 32'd1);
    chk("accepted", 32'(idx), 32'(sess.size()));
    in_valid_i = 0;
    mem_ready_i = 1;
  endtask

  function automatic desc_t rand_desc(input bit last);
    int op, imm;
    op = ($urandom_range(0, 9) == 0) ? int'($urandom_range(9, 15)) : int'($urandom_range(0, 8));
    if ($urandom_range(0, 3) == 0) imm = int'($urandom_range(0, 8191));
    else imm = int'($urandom_range(0, 4095)) - 2048;
    if (op == 8 && $urandom_range(0, 3) != 0) imm = imm & ~1;
    return mk(op, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
              int'($urandom_range(0, 31)), imm, last);
  endfunction

  initial begin
    int n, acc2, wr2, nd2, idx2;
    desc_t d2[3];
    logic [31:0] w2[3];
    rst_i = 0; start_i = 0; in_valid_i = 0; mem_ready_i = 1; in_last_i = 0;
    in_op_i = 0; in_rd_i = 0; in_rs1_i = 0; in_rs2_i = 0; in_imm_i = 0;
    start2 = 0; valid2 = 0; mready2 = 1;
    cur = mk(0, 0, 0, 0, 0, 0);
    model_reset();
    n_done = 0;
    @(negedge clk); @(negedge clk);
    #2;
    chk("rst_mem_valid", 32'(mem_valid_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_count", 32'(count_o), 32'd0);
    chk("rst_in_ready", 32'(in_ready_o), 32'd0);
    @(negedge clk);
    rst_i = 1;
    tick();

    // Reset with a pending write
    start_i = 1; tick(); start_i = 0;
    cur = mk(0, 1, 2, 3, 0, 0); drive_cur();
    in_valid_i = 1; mem_ready_i = 0; tick();
    in_valid_i = 0; tick();
    rst_i = 0;
    #2;
    chk("midrst_mem_valid", 32'(mem_valid_o), 32'd0);
    chk("midrst_addr", mem_addr_o, 32'd0);
    chk("midrst_data", mem_data_o, 32'd0);
    chk("midrst_count", 32'(count_o), 32'd0);
    chk("midrst_busy", 32'(busy_o), 32'd0);
    chk("midrst_done", 32'(done_o), 32'd0);
    chk("midrst_err", 32'(err_o), 32'd0);
    chk("midrst_in_ready", 32'(in_ready_o), 32'd0);
    model_reset();
    @(negedge clk);
    rst_i = 1; mem_ready_i = 1;
    tick();

    // add/sub back-to-back
    sess.delete();
    sess.push_back(mkw(0, 3, 1, 2, 0, 0, 32'h002081B3));
    sess.push_back(mkw(1, 5, 6, 7, 0, 1, 32'h407302B3));
    run_session(100, 100, 0);

    // I/S/B formats
    sess.delete();
    sess.push_back(mkw(5, 1, 0, 0, -1, 0, 32'hFFF00093));
    sess.push_back(mkw(6, 4, 0, 0, 0, 0, 32'h00002203));
    sess.push_back(mkw(7, 0, 1, 2, 8, 0, 32'h0020A423));
    sess.push_back(mkw(8, 0, 1, 2, -4, 1, 32'hFE208EE3));
    run_session(100, 100, 0);
    chk("four_count", 32'(count_o), 32'd4);

    // Backpressure stall
    sess.delete();
    sess.push_back(mk(0, 9, 10, 11, 0, 0));
    sess.push_back(mk(1, 12, 13, 14, 0, 0));
    sess.push_back(mk(4, 15, 16, 17, 0, 1));
    run_session(100, 100, 3);

    // Illegal descriptors
    sess.delete();
    sess.push_back(mkw(12, 1, 2, 3, 0, 0, 32'h00000013));
    sess.push_back(mkw(5, 1, 2, 3, 2048, 0, 32'h00000013));
    sess.push_back(mkw(8, 0, 1, 2, 3, 1, 32'h00000013));
    run_session(100, 100, 0);
    chk("illegal_err", 32'(err_o), 32'd1);

    // Random sessions
    for (int s = 0; s < 20; s++) begin
      sess.delete();
      n = int'($urandom_range(1, 10));
      for (int k = 0; k < n; k++) sess.push_back(rand_desc(k == n - 1));
      run_session(70, 60, 0);
    end

    // Overflow on the DEPTH=2 instance
    d2[0] = mk(0, 1, 2, 3, 0, 0);
    d2[1] = mk(4, 4, 5, 6, 0, 0);
    d2[2] = mk(1, 7, 8, 9, 0, 0);
    w2[0] = 32'h003100B3;
    w2[1] = 32'h0062E233;
    w2[2] = 32'h0;
    acc2 = 0; wr2 = 0; nd2 = 0; idx2 = 0;
    start2 = 1; #2; @(negedge clk); start2 = 0;
    for (int c = 0; c < 12; c++) begin
      cur = d2[idx2]; drive_cur();
      valid2 = 1;
      #2;
      if (mem_valid2 && mready2) begin
        if (wr2 < 2) begin
          chk("ovf_addr", mem_addr2, BASE2 + 32'(wr2 * 4));
          chk("ovf_data", mem_data2, w2[wr2]);
        end
        wr2++;
      end
      if (done2) nd2++;
      if (valid2 && in_ready2) begin
        acc2++;
        if (idx2 < 2) idx2++;
      end
      @(negedge clk);
    end
    valid2 = 0;
    chk("ovf_accepts", 32'(acc2), 32'd2);
    chk("ovf_writes", 32'(wr2), 32'd2);
    chk("ovf_err", 32'(err2), 32'd1);
    chk("ovf_done", 32'(nd2), 32'd1);
    chk("ovf_count", 32'(count2), 32'd2);
    chk("ovf_busy", 32'(busy2), 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/inst_stream_encoder.md
Name: inst_stream_encoder

Overview:
- Encoder/loader on the opposite side of the pipeline's instruction decoder.
- Accepts abstract instruction descriptors over a valid/ready handshake and encodes them into RV32 words for the supported subset: add, sub, mul, and, or, addi, lw, sw, beq.
- Writes the encoded words sequentially into instruction memory through a backpressured write port.
- Used by the bench and boot logic to fill instruction memory before start.

Parameters:
- BASE_ADDR, 32'h0, byte address of the first instruction written in a session.
- DEPTH, 256, maximum number of instructions per session; must be at least 1.
- CNT_W, $clog2(DEPTH+1), width of count_o.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- start_i  in  1  starts a load session; honoured only in IDLE.
- in_valid_i  in  1  descriptor valid.
- in_ready_o  out  1  descriptor accepted when in_valid_i && in_ready_o.
- in_op_i  in  4  0 ADD, 1 SUB, 2 MUL, 3 AND, 4 OR, 5 ADDI, 6 LW, 7 SW, 8 BEQ; 9-15 illegal.
- in_rd_i  in  5  destination register.
- in_rs1_i  in  5  source register 1.
- in_rs2_i  in  5  source register 2.
- in_imm_i  in  13  signed immediate; byte offset for BEQ.
- in_last_i  in  1  marks the final descriptor of the session.
- mem_valid_o  out  1  write request.
- mem_ready_i  in  1  memory accepts the write.
- mem_addr_o  out  32  byte address of the write.
- mem_data_o  out  32  encoded instruction word.
- count_o  out  CNT_W  number of descriptors accepted in the current session.
- busy_o  out  1  high in LOAD and DRAIN.
- done_o  out  1  one-cycle pulse at session end.
- err_o  out  1  sticky error flag; cleared by start_i.

Behaviour:
- Reset: asynchronous, active low. All outputs are 0, state is IDLE, count is 0. Any pending write is dropped.
- States:
  - IDLE: start_i moves to LOAD; count and err are cleared.
  - LOAD: accepts descriptors. An accept with in_last_i=1, or an accept that brings count to DEPTH, moves to DRAIN.
  - DRAIN: waits until the output register is empty, then moves to DONE.
  - DONE: done_o=1 for exactly one cycle, then IDLE.
- start_i is ignored outside IDLE.
- in_ready_o = (state==LOAD) && (count<DEPTH) && (!mem_valid_o || mem_ready_i).
- Latency and addressing:
  - One-entry output register; an accepted descriptor appears on mem_* in the following cycle.
  - mem_addr_o = BASE_ADDR + 4*count, using count before the increment.
  - count increments on each accept.
- Output holding: mem_valid_o, mem_addr_o and mem_data_o hold stable until mem_ready_i. A simultaneous accept and write-out refills the register back-to-back, giving 1 instruction per cycle.
- Encoding:
  - R-type (opcode 0110011), funct3 / funct7 per op:
    - ADD: 000 / 0000000
    - SUB: 000 / 0100000
    - MUL: 000 / 0000001
    - AND: 111 / 0000000
    - OR: 110 / 0000000
  - ADDI: opcode 0010011, f3 000, I-format.
  - LW: opcode 0000011, f3 010, I-format.
  - SW: opcode 0100011, f3 010, S-format.
  - BEQ: opcode 1100011, f3 000, B-format using imm[12:1].
  - R-type ignores in_imm_i. ADDI/LW/SW ignore rs2. SW/BEQ ignore rd.
- Illegal descriptors: an illegal op, an ADDI/LW/SW immediate outside -2048..2047 (in_imm_i[12]!=in_imm_i[11]), or BEQ with in_imm_i[0]=1.
  - The descriptor is still accepted and counted.
  - The written word is the NOP 32'h00000013.
  - err_o is set and stays set until the next start_i.
- Overflow: reaching DEPTH without in_last_i sets err_o and ends the session through DRAIN/DONE.
- Protocol: in_valid_i outside LOAD is not an error and is simply not accepted.

Decomposition:
- Package inst_enc_pkg holds:
  - the op enum (4 bits)
  - opcode constants: OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH
  - funct3/funct7 constants
  - NOP_WORD
  - the state enum
- Sub-module inst_word_encoder: purely combinational; {op, rd, rs1, rs2, imm} -> {word[31:0], illegal}. The top level holds the FSM, count, output register and handshake.

Test Plan:
- Reset mid-session with mem_valid_o=1 -> next cycle all outputs 0, state IDLE; a following start_i gives count_o=0 and first address BASE_ADDR.
- start, then add x3,x1,x2; sub x5,x6,x7 back-to-back with mem_ready_i=1 -> writes 0x002081B3 @0 and 0x407302B3 @4 on consecutive cycles; no bubble.
- addi x1,x0,-1; lw x4,0(x0); sw x2,8(x1); beq x1,x2,-4 (last) -> 0xFFF00093, 0x00002203, 0x0020A423, 0xFE208EE3 at 0/4/8/12; count_o=4; done_o pulses once after the last write.
- mem_ready_i held low 3 cycles with in_valid_i=1 -> in_ready_o=0, mem_* stable; after release, the next descriptor follows one cycle later.
- Illegal cases: op=12, addi imm=2048, beq imm=3 -> each writes 0x00000013; err_o rises on the first and stays high; the next start_i clears it.
- DEPTH=2 session without in_last_i -> 2 writes, the third descriptor is not accepted, err_o=1, done_o pulses.
